// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave
// ---------------------------------------------------------------------------
// AHB-Lite slave backed by a word-organised on-chip memory. The slave accepts
// byte, halfword and word transfers, writes them through per-byte lane
// enables, returns full 32-bit read words and can stretch every data phase by
// a fixed number of wait states.
//
// Optional feature macro: AHB_SRAM_SLAVE_ERR_EN
//   defined   : out-of-range or misaligned/oversized accesses get the
//               two-cycle ERROR response (ERR1, ERR2) and never touch memory.
//   undefined : hresp is tied to 0, the word index wraps modulo DEPTH,
//               oversized hsize is treated as word and misaligned low address
//               bits are cleared to the natural alignment.
//
// Parameters
//   AW          address width
//   DW          data width (only 32 is supported)
//   DEPTH       memory size in 32-bit words (power of two, >= 4)
//   BASE        byte address of word 0 (aligned to DEPTH*4)
//   WAIT_STATES wait cycles inserted into every data phase (0..15)
//
// Ports
//   hclk       clock, all state updates on the rising edge
//   hreset     asynchronous active-high reset
//   hsel       slave select from the address decoder
//   haddr      byte address (address phase)
//   htrans     IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
//   hsize      000 byte, 001 halfword, 010 word
//   hwrite     1 = write
//   hwdata     write data (data phase)
//   hready     bus-level ready, previous transfer has completed
//   hreadyout  this slave's ready
//   hresp      0 = OKAY, 1 = ERROR
//   hrdata     read data (data phase), zero outside a read completion cycle
// ---------------------------------------------------------------------------
module ahb_sram_slave #(
    parameter int unsigned    AW          = 32,
    parameter int unsigned    DW          = 32,
    parameter int unsigned    DEPTH       = 256,
    parameter logic [AW-1:0]  BASE        = '0,
    parameter int unsigned    WAIT_STATES = 0
) (
    input  logic          hclk,
    input  logic          hreset,
    input  logic          hsel,
    input  logic [AW-1:0] haddr,
    input  logic [1:0]    htrans,
    input  logic [2:0]    hsize,
    input  logic          hwrite,
    input  logic [DW-1:0] hwdata,
    input  logic          hready,
    output logic          hreadyout,
    output logic          hresp,
    output logic [DW-1:0] hrdata
);

    localparam int unsigned IW      = $clog2(DEPTH);
    localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_XFER
`ifdef AHB_SRAM_SLAVE_ERR_EN
        ,
        S_ERR1,
        S_ERR2
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    wait_q, wait_d;
    logic [AW-1:0] addr_q;
    logic [1:0]    size_q;
    logic          write_q;

    logic          accept;
    logic          load;
    logic          rdy;
    logic          rsp;
    logic [1:0]    size_eff;
    logic [AW-1:0] addr_eff;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] off_q;
    logic [IW-1:0] idx;
    logic [3:0]    be;

    assign accept = hsel && hready && htrans[1];

    // Oversized transfers collapse to word; low address bits below the
    // natural alignment are cleared so the stored address is always aligned.
    always_comb begin
        size_eff = (hsize > 3'b010) ? 2'd2 : hsize[1:0];
        addr_eff = haddr;
        case (size_eff)
            2'd1:    addr_eff[0]   = 1'b0;
            2'd2:    addr_eff[1:0] = 2'b00;
            default: ;
        endcase
    end

`ifdef AHB_SRAM_SLAVE_ERR_EN
    logic [AW-1:0] off_a;
    logic          legal;

    // Range test on the BASE-relative offset avoids overflow of BASE+DEPTH*4
    // at the top of the address space.
    always_comb begin
        off_a = haddr - BASE;
        legal = (haddr >= BASE) &&
                ((off_a >> (IW + 2)) == '0) &&
                (hsize <= 3'b010) &&
                (haddr == addr_eff);
    end
`endif

    // Next state and handshake outputs
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        load    = 1'b0;
        rdy     = 1'b1;
        rsp     = 1'b0;

        case (state_q)
            S_WAIT: begin
                rdy = 1'b0;
                if (wait_q == '0) begin
                    state_d = S_XFER;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
`ifdef AHB_SRAM_SLAVE_ERR_EN
            S_ERR1: begin
                rdy     = 1'b0;
                rsp     = 1'b1;
                state_d = S_ERR2;
            end
            S_ERR2: rsp = 1'b1;
`endif
            default: ;
        endcase

        // IDLE, XFER and ERR2 all present ready, so each may take a new
        // address phase; WAIT and ERR1 ignore the held next address.
        if (rdy) begin
            state_d = S_IDLE;
            if (accept) begin
                load = 1'b1;
`ifdef AHB_SRAM_SLAVE_ERR_EN
                if (!legal) begin
                    state_d = S_ERR1;
                end else
`endif
                if (WAIT_STATES > 0) begin
                    state_d = S_WAIT;
                    wait_d  = WS_LOAD;
                end else begin
                    state_d = S_XFER;
                end
            end
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (load) begin
                addr_q  <= addr_eff;
                size_q  <= size_eff;
                write_q <= hwrite;
            end
        end
    end

    // Word index; taking only IW bits gives the modulo-DEPTH wrap.
    assign off_q = addr_q - BASE;
    assign idx   = off_q[IW+1:2];

    always_comb begin
        case (size_q)
            2'd0:    be = 4'b0001 << addr_q[1:0];
            2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // Memory is not reset; an async reset forces IDLE so a pending write
    // never reaches this block.
    always_ff @(posedge hclk) begin
        if (state_q == S_XFER && write_q) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

    assign hreadyout = rdy;
    assign hresp     = rsp;

    always_comb begin
        hrdata = '0;
        if (state_q == S_XFER && !write_q) begin
            hrdata = mem[idx];
        end
    end

    logic unused_bits;
    assign unused_bits = ^{htrans[0], off_q[AW-1:IW+2], off_q[1:0]};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Testbench for ahb_sram_slave: two instances (zero wait states and three
// wait states) each driven by its own pipelined AHB-Lite master. Expected
// responses are pushed at address-phase accept and checked by a separate
// monitor per instance against a byte-level memory model.
module tb_ahb_sram_slave;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h40;
    localparam int unsigned NRAND = 220;

    typedef struct {
        bit          err;
        int unsigned low;
        logic [31:0] rdata;
    } exp_t;

    logic        hclk;
    logic        hreset_v    [2];
    logic        hsel_v      [2];
    logic [31:0] haddr_v     [2];
    logic [1:0]  htrans_v    [2];
    logic [2:0]  hsize_v     [2];
    logic        hwrite_v    [2];
    logic [31:0] hwdata_v    [2];
    logic        hreadyout_v [2];
    logic        hresp_v     [2];
    logic [31:0] hrdata_v    [2];

    bit          mon_en [2];
    bit          done_v [2];
    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] mm [2][DEPTH];

    int checks   = 0;
    int failures = 0;

    ahb_sram_slave #(
        .AW(32), .DW(32), .DEPTH(DEPTH), .BASE(BASE), .WAIT_STATES(0)
    ) u0 (
        .hclk(hclk), .hreset(hreset_v[0]), .hsel(hsel_v[0]), .haddr(haddr_v[0]),
        .htrans(htrans_v[0]), .hsize(hsize_v[0]), .hwrite(hwrite_v[0]),
        .hwdata(hwdata_v[0]), .hready(hreadyout_v[0]), .hreadyout(hreadyout_v[0]),
        .hresp(hresp_v[0]), .hrdata(hrdata_v[0])
    );

    ahb_sram_slave #(
        .AW(32), .DW(32), .DEPTH(DEPTH), .BASE(BASE), .WAIT_STATES(3)
    ) u1 (
        .hclk(hclk), .hreset(hreset_v[1]), .hsel(hsel_v[1]), .haddr(haddr_v[1]),
        .htrans(htrans_v[1]), .hsize(hsize_v[1]), .hwrite(hwrite_v[1]),
        .hwdata(hwdata_v[1]), .hready(hreadyout_v[1]), .hreadyout(hreadyout_v[1]),
        .hresp(hresp_v[1]), .hrdata(hrdata_v[1])
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    function automatic int unsigned ws(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic void chk(input string nm, input int k,
                                input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
        end
    endfunction

    function automatic void qpush(input int k, input exp_t e);
        if (k == 0) q0.push_back(e); else q1.push_back(e);
    endfunction

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t qpop(input int k);
        if (k == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic exp_t qfront(input int k);
        if (k == 0) return q0[0];
        return q1[0];
    endfunction

    // Reference model: a transfer covers the byte range [a, a+nbytes) after
    // natural alignment; the containing word is ((a-BASE)/4) mod DEPTH.
    function automatic exp_t model(input int k, input logic [31:0] a, input logic [2:0] sz,
                                   input bit w, input logic [31:0] wd);
        exp_t        e;
        int unsigned nbytes;
        int unsigned idx;
        int unsigned lo;
        logic [31:0] aa;
        e.err   = 1'b0;
        e.low   = ws(k);
        e.rdata = '0;
        nbytes  = (sz > 3'd2) ? 4 : (1 << sz);
`ifdef AHB_SRAM_SLAVE_ERR_EN
        if (a < BASE || a >= BASE + DEPTH * 4 || sz > 3'd2 || (a % nbytes) != 0) begin
            e.err = 1'b1;
            e.low = 1;
            return e;
        end
`endif
        aa  = a - (a % nbytes);
        idx = ((aa - BASE) / 4) % DEPTH;
        lo  = aa % 4;
        if (w) begin
            for (int unsigned b = 0; b < 4; b++)
                if (b >= lo && b < lo + nbytes)
                    mm[k][idx][8*b +: 8] = wd[8*b +: 8];
        end else begin
            e.rdata = mm[k][idx];
        end
        return e;
    endfunction

    // Wait for the clock edge that completes the current bus cycle.
    task automatic wait_edge(input int k);
        int unsigned n = 0;
        while (1) begin
            @(negedge hclk);
            if (hreadyout_v[k] === 1'b1) break;
            n++;
            if (n > 40) begin
                checks++;
                failures++;
                $display("FAIL ready_timeout dut%0d: got stuck-low expected hreadyout=1 within 40 cycles", k);
                break;
            end
        end
        @(posedge hclk);
        #1;
    endtask

    task automatic issue(input int k, input bit sel, input logic [1:0] trans,
                         input logic [31:0] a, input logic [2:0] sz,
                         input bit w, input logic [31:0] wd);
        hsel_v[k]   = sel;
        htrans_v[k] = trans;
        haddr_v[k]  = a;
        hsize_v[k]  = sz;
        hwrite_v[k] = w;
        wait_edge(k);
        if (sel && trans[1]) begin
            qpush(k, model(k, a, sz, w, wd));
            hwdata_v[k] = w ? wd : $urandom;
        end
    endtask

    task automatic idle(input int k);
        issue(k, 1'b0, 2'b00, $urandom, 3'd2, 1'b0, 32'h0);
    endtask

    task automatic mon(input int k);
        int unsigned low = 0;
        exp_t        e;
        while (!done_v[k]) begin
            @(negedge hclk);
            if (!mon_en[k]) begin
                low = 0;
            end else if (qsize(k) == 0) begin
                chk("idle_ready", k, {31'b0, hreadyout_v[k]}, 32'd1);
                chk("idle_resp",  k, {31'b0, hresp_v[k]},     32'd0);
                chk("idle_rdata", k, hrdata_v[k],             32'd0);
            end else begin
                e = qfront(k);
                if (hreadyout_v[k] !== 1'b1) begin
                    low++;
                    chk("stall_resp",  k, {31'b0, hresp_v[k]}, {31'b0, e.err});
                    chk("stall_rdata", k, hrdata_v[k],         32'd0);
                end else begin
                    e = qpop(k);
                    chk("stall_cycles", k, low,                 e.low);
                    chk("resp",         k, {31'b0, hresp_v[k]}, {31'b0, e.err});
                    chk("rdata",        k, hrdata_v[k],         e.rdata);
                    low = 0;
                end
            end
        end
    endtask

    task automatic reset_test(input int k);
        mon_en[k]   = 1'b0;
        hsel_v[k]   = 1'b1;
        htrans_v[k] = 2'b10;
        haddr_v[k]  = BASE + 32'h10;
        hsize_v[k]  = 3'd2;
        hwrite_v[k] = 1'b1;
        wait_edge(k);
        hwdata_v[k] = 32'hC0FFEE00;
        hsel_v[k]   = 1'b0;
        htrans_v[k] = 2'b00;
        @(negedge hclk);
        chk("rst_pre_wait", k, {31'b0, hreadyout_v[k]}, 32'd0);
        #2 hreset_v[k] = 1'b1;
        #1;
        chk("rst_async_ready", k, {31'b0, hreadyout_v[k]}, 32'd1);
        chk("rst_async_resp",  k, {31'b0, hresp_v[k]},     32'd0);
        chk("rst_async_rdata", k, hrdata_v[k],             32'd0);
        @(negedge hclk);
        hreset_v[k] = 1'b0;
        repeat (4) @(posedge hclk);
        #1;
        mon_en[k] = 1'b1;
        // The aborted write must not have landed: model still holds old data.
        issue(k, 1'b1, 2'b10, BASE + 32'h10, 3'd2, 1'b0, 32'h0);
        repeat (3) idle(k);
    endtask

    task automatic drive(input int k);
        logic [31:0] a;
        logic [2:0]  sz;
        int unsigned r;

        hreset_v[k] = 1'b1;
        hsel_v[k]   = 1'b0;
        htrans_v[k] = 2'b00;
        haddr_v[k]  = '0;
        hsize_v[k]  = '0;
        hwrite_v[k] = 1'b0;
        hwdata_v[k] = '0;
        repeat (3) @(posedge hclk);
        #1;
        chk("reset_ready", k, {31'b0, hreadyout_v[k]}, 32'd1);
        chk("reset_resp",  k, {31'b0, hresp_v[k]},     32'd0);
        chk("reset_rdata", k, hrdata_v[k],             32'd0);
        @(negedge hclk);
        hreset_v[k] = 1'b0;
        @(posedge hclk);
        #1;
        mon_en[k] = 1'b1;

        for (int unsigned i = 0; i < DEPTH; i++)
            issue(k, 1'b1, 2'b10, BASE + 4 * i, 3'd2, 1'b1, $urandom);

        // Back-to-back write then read of the same word
        issue(k, 1'b1, 2'b10, BASE + 32'h04, 3'd2, 1'b1, 32'hDEADBEEF);
        issue(k, 1'b1, 2'b10, BASE + 32'h04, 3'd2, 1'b0, 32'h0);
        // Lane writes
        issue(k, 1'b1, 2'b10, BASE + 32'h08, 3'd2, 1'b1, 32'h00000000);
        issue(k, 1'b1, 2'b11, BASE + 32'h09, 3'd0, 1'b1, 32'h0000AA00);
        issue(k, 1'b1, 2'b11, BASE + 32'h0A, 3'd1, 1'b1, 32'h12340000);
        issue(k, 1'b1, 2'b10, BASE + 32'h08, 3'd2, 1'b0, 32'h0);
        idle(k);
        issue(k, 1'b1, 2'b10, BASE, 3'd2, 1'b0, 32'h0);
        idle(k);
`ifdef AHB_SRAM_SLAVE_ERR_EN
        issue(k, 1'b1, 2'b10, BASE + DEPTH * 4, 3'd2, 1'b0, 32'h0);
        issue(k, 1'b1, 2'b10, BASE, 3'd2, 1'b1, 32'h600DF00D);
        issue(k, 1'b1, 2'b10, BASE + 32'h06, 3'd2, 1'b1, 32'hBAD0BAD0);
        issue(k, 1'b1, 2'b10, BASE, 3'd2, 1'b0, 32'h0);
`else
        issue(k, 1'b1, 2'b10, BASE + DEPTH * 4, 3'd2, 1'b1, 32'h00000055);
        issue(k, 1'b1, 2'b10, BASE, 3'd2, 1'b0, 32'h0);
        issue(k, 1'b1, 2'b10, BASE + 32'h07, 3'd5, 1'b1, 32'hA5A55A5A);
        issue(k, 1'b1, 2'b10, BASE + 32'h04, 3'd2, 1'b0, 32'h0);
`endif
        idle(k);

        repeat (NRAND) begin
            r  = $urandom_range(0, 9);
            a  = BASE - 32 + $urandom_range(0, DEPTH * 4 + 63);
            sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            case (r)
                0:       issue(k, 1'b0, 2'b10, a, sz, 1'($urandom), $urandom);
                1:       issue(k, 1'b1, 2'($urandom_range(0, 1)), a, sz, 1'($urandom), $urandom);
                default: issue(k, 1'b1, {1'b1, 1'($urandom)}, a, sz, 1'($urandom), $urandom);
            endcase
        end
        repeat (3) idle(k);
        chk("drain", k, qsize(k), 32'd0);

        if (k == 1) reset_test(k);
        done_v[k] = 1'b1;
    endtask

    initial begin
        fork
            drive(0);
            drive(1);
            mon(0);
            mon(1);
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before 2ms");
        $fatal(1, "watchdog");
    end

endmodule
